// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU
// control codes, datapath mux selects, condition codes and opcode classes.
package arm_ctrl_pkg;

    // FSM state encoding; the numeric values are visible on state_o.
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    // ALUControl codes (low three bits of the port).
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;

    // Data-processing cmd field, Instr[24:21] = Funct[4:1].
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // ResultSrc selects.
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcB selects.
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ImmSrc extender modes.
    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    // Opcode classes, Instr[27:26].
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Condition codes, Instr[31:28].
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/arm_cond_unit.sv
// Conditional-execution unit: registered NZCV flags, the CondEx table and
// the per-instruction condition latch.
//   clk, rst_n   : clock, synchronous active-low reset
//   cond         : Instr[31:28]
//   alu_flags    : NZCV produced by the ALU this cycle
//   flag_w       : {NZ write, CV write} for the current instruction
//   latch_en     : high in DECODE; captures CondEx for the instruction
//   update_en    : high in EXECR/EXECI; allows the flag write on exit
//   flags        : registered NZCV
//   cond_ex_q    : latched condition result gating architectural writes
module arm_cond_unit
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST   = 4'b0000,
    parameter bit         NV_EXECUTES = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       latch_en,
    input  logic       update_en,
    output logic [3:0] flags,
    output logic       cond_ex_q
);

    logic n, z, c, v;
    logic cond_ex;

    assign {n, z, c, v} = flags;

    // ARM condition table evaluated against the registered flags.
    always_comb begin : cond_table
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = NV_EXECUTES;
        endcase
    end

    // Condition is frozen at DECODE so the instruction's own flag update
    // cannot flip its later write enables.
    always_ff @(posedge clk) begin : flag_reg
        if (!rst_n) begin
            flags     <= FLAGS_RST;
            cond_ex_q <= 1'b0;
        end else begin
            if (latch_en) begin
                cond_ex_q <= cond_ex;
            end
            if (update_en && cond_ex_q) begin
                if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
                if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
            end
        end
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, ALU decode, and conditional gating of all writes.
//   clk, rst_n         : clock, synchronous active-low reset
//   Cond/Op/Funct/Rd   : instruction register fields
//   ALUFlags           : NZCV from the ALU this cycle
//   PCWrite .. RegW    : write enables (forced low while rst_n is low)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc : datapath selects
//   ALUControl         : ALU operation
//   Flags              : registered NZCV
//   state_o, illegal_o : debug state and illegal-opcode pulse
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W   = 3,
    parameter logic [3:0]  FLAGS_RST   = 4'b0000,
    parameter bit          NV_EXECUTES = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           Cond,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 MemW,
    output logic                 RegW,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           Flags,
    output logic [3:0]           state_o,
    output logic                 illegal_o
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cmd;
    logic       is_cmp;
    logic       is_exec;
    logic       is_rd15;
    logic       cond_ex_q;
    logic [1:0] flag_w;
    logic [2:0] alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       mem_w;
    logic       reg_w;
    logic       illegal;

    assign cmd     = Funct[4:1];
    assign is_cmp  = (cmd == CMD_CMP);
    assign is_exec = (state_q == EXECR) || (state_q == EXECI);
    assign is_rd15 = (Rd == 4'd15);

    // State register.
    always_ff @(posedge clk) begin : state_reg
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin : fsm_comb
        state_d   = state_q;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_w     = 1'b0;
        reg_w     = 1'b0;
        illegal   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ImmSrc    = IMM_8;
        case (state_q)
            FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                state_d   = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (Op)
                    OP_DP:   state_d = Funct[5] ? EXECI : EXECR;
                    OP_MEM:  state_d = MEMADR;
                    OP_BR:   state_d = BRANCH;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_12;
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = cond_ex_q;
                pc_write  = cond_ex_q & is_rd15;
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc  = 1'b1;
                mem_w   = cond_ex_q;
                state_d = FETCH;
            end
            EXECR: begin
                ALUSrcB = SRCB_RD2;
                state_d = is_cmp ? FETCH : ALUWB;
            end
            EXECI: begin
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_8;
                state_d = is_cmp ? FETCH : ALUWB;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_w     = cond_ex_q;
                pc_write  = cond_ex_q & is_rd15;
                state_d   = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_24;
                ResultSrc = RES_ALURESULT;
                pc_write  = cond_ex_q;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // ALU operation; only the execute states decode cmd, everything else adds.
    always_comb begin : alu_decode
        alu_op = ALU_ADD;
        if (is_exec) begin
            case (cmd)
                CMD_ADD: alu_op = ALU_ADD;
                CMD_SUB: alu_op = ALU_SUB;
                CMD_CMP: alu_op = ALU_SUB;
                CMD_AND: alu_op = ALU_AND;
                CMD_ORR: alu_op = ALU_ORR;
                CMD_MOV: alu_op = ALU_MOV;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

    // S bit writes NZ; CV only for arithmetic; CMP always writes all four.
    assign flag_w[1] = Funct[0] | is_cmp;
    assign flag_w[0] = (Funct[0] & ((cmd == CMD_ADD) | (cmd == CMD_SUB))) | is_cmp;

    arm_cond_unit #(
        .FLAGS_RST   (FLAGS_RST),
        .NV_EXECUTES (NV_EXECUTES)
    ) u_cond (
        .clk       (clk),
        .rst_n     (rst_n),
        .cond      (Cond),
        .alu_flags (ALUFlags),
        .flag_w    (flag_w),
        .latch_en  (state_q == DECODE),
        .update_en (is_exec),
        .flags     (Flags),
        .cond_ex_q (cond_ex_q)
    );

    // Write enables are held off for the whole reset window.
    assign PCWrite    = pc_write & rst_n;
    assign IRWrite    = ir_write & rst_n;
    assign MemW       = mem_w & rst_n;
    assign RegW       = reg_w & rst_n;
    assign illegal_o  = illegal & rst_n;
    assign RegSrc     = {(Op == OP_MEM) & ~Funct[0], Op == OP_BR};
    assign ALUControl = ALUCTRL_W'(alu_op);
    assign state_o    = state_q;

endmodule
